// File: rtl/shared_buffer_vc_list_ctrl_if.sv
// Port bundle between the shared-buffer VC list controller and its user/tracker side.
// master: drives requests and tracker status; slave: the list controller itself.
interface shared_buffer_vc_list_ctrl_if #(
  parameter int unsigned memory_bank_depth = 32,
  parameter int unsigned num_vcs           = 4,
  parameter int unsigned flit_data_width   = 64
);
  localparam int unsigned addr_w = $clog2(memory_bank_depth);
  localparam int unsigned vc_w   = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int unsigned cnt_w  = addr_w + 1;

  logic                       wr_valid;
  logic [vc_w-1:0]            wr_vc;
  logic [flit_data_width-1:0] wr_data;
  logic                       wr_ready;
  logic                       rd_valid;
  logic [vc_w-1:0]            rd_vc;
  logic [flit_data_width-1:0] rd_data;
  logic                       rd_data_valid;
  logic [num_vcs-1:0]         vc_empty;
  logic [num_vcs*cnt_w-1:0]   vc_count;
  logic [addr_w-1:0]          available_flit_addr;
  logic                       tracker_empty;
  logic                       allocate_addr;
  logic                       reclaim_addr;
  logic [addr_w-1:0]          freed_flit_addr;
  logic                       err_flag;

  modport master (
    output wr_valid, wr_vc, wr_data, rd_valid, rd_vc, available_flit_addr, tracker_empty,
    input  wr_ready, rd_data, rd_data_valid, vc_empty, vc_count, allocate_addr, reclaim_addr,
           freed_flit_addr, err_flag
  );

  modport slave (
    input  wr_valid, wr_vc, wr_data, rd_valid, rd_vc, available_flit_addr, tracker_empty,
    output wr_ready, rd_data, rd_data_valid, vc_empty, vc_count, allocate_addr, reclaim_addr,
           freed_flit_addr, err_flag
  );
endinterface

// File: rtl/shared_buffer_vc_list_ctrl.sv
// Per-VC linked lists over a shared flit bank; addresses come from / return to a free tracker.
// Optional sticky protocol checker enabled by defining SHARED_BUF_ERR_CHK_EN.
module shared_buffer_vc_list_ctrl #(
  parameter int unsigned memory_bank_depth = 32,
  parameter int unsigned num_vcs           = 4,
  parameter int unsigned flit_data_width   = 64
) (
  input logic                         clk,
  input logic                         reset,
  shared_buffer_vc_list_ctrl_if.slave bus
);
  localparam int unsigned addr_w = $clog2(memory_bank_depth);
  localparam int unsigned vc_w   = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int unsigned cnt_w  = addr_w + 1;

  logic [flit_data_width-1:0] mem      [memory_bank_depth];
  logic [addr_w-1:0]          next_ptr [memory_bank_depth];
  logic [addr_w-1:0]          head_q   [num_vcs];
  logic [addr_w-1:0]          tail_q   [num_vcs];
  logic [cnt_w-1:0]           count_q  [num_vcs];
  logic [cnt_w-1:0]           count_d  [num_vcs];
  logic [flit_data_width-1:0] rd_data_q;
  logic                       rd_data_valid_q;

  logic              rd_fire, wr_fire, wr_ready, handoff, wr_new_head;
  logic [addr_w-1:0] wr_addr, rd_head;

  always_comb begin
    wr_addr  = bus.available_flit_addr;
    rd_head  = head_q[bus.rd_vc];
    rd_fire  = bus.rd_valid && (count_q[bus.rd_vc] != '0);
    wr_ready = !bus.tracker_empty || rd_fire;
    wr_fire  = bus.wr_valid && wr_ready;
    // Last flit of a VC leaves while a new one arrives: the new flit becomes head and tail.
    handoff  = rd_fire && (bus.rd_vc == bus.wr_vc) && (count_q[bus.wr_vc] == cnt_w'(1));
    wr_new_head = (count_q[bus.wr_vc] == '0) || handoff;
  end

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      count_d[v] = count_q[v];
      if (wr_fire && (bus.wr_vc == vc_w'(v))) count_d[v] = count_d[v] + cnt_w'(1);
      if (rd_fire && (bus.rd_vc == vc_w'(v))) count_d[v] = count_d[v] - cnt_w'(1);
    end
  end

  always_comb begin
    bus.wr_ready        = wr_ready;
    bus.allocate_addr   = wr_fire && !reset;
    bus.reclaim_addr    = rd_fire && !reset;
    bus.freed_flit_addr = rd_head;
    bus.rd_data         = rd_data_q;
    bus.rd_data_valid   = rd_data_valid_q;
    bus.vc_empty        = '0;
    bus.vc_count        = '0;
    for (int v = 0; v < num_vcs; v++) begin
      bus.vc_empty[v]                 = (count_q[v] == '0);
      bus.vc_count[v*cnt_w +: cnt_w]  = count_q[v];
    end
  end

  // Storage arrays are never reset; stale contents are unreachable once counts clear.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= bus.wr_data;
      if (!wr_new_head) next_ptr[tail_q[bus.wr_vc]] <= wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      for (int v = 0; v < num_vcs; v++) count_q[v] <= '0;
    end else begin
      rd_data_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q            <= mem[rd_head];
        head_q[bus.rd_vc]    <= next_ptr[rd_head];
      end
      // Placed after the read update so a handoff overrides the head advance.
      if (wr_fire) begin
        tail_q[bus.wr_vc] <= wr_addr;
        if (wr_new_head) head_q[bus.wr_vc] <= wr_addr;
      end
      for (int v = 0; v < num_vcs; v++) count_q[v] <= count_d[v];
    end
  end

`ifdef SHARED_BUF_ERR_CHK_EN
  logic        err_q;
  logic [31:0] count_sum;

  always_comb begin
    count_sum = '0;
    for (int v = 0; v < num_vcs; v++) count_sum = count_sum + 32'(count_q[v]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((bus.rd_valid && !rd_fire) || (bus.wr_valid && !wr_ready) ||
                 (count_sum > 32'(memory_bank_depth))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_flag = err_q;
`else
  assign bus.err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_shared_buffer_vc_list_ctrl.sv
// Self-checking bench: per-VC FIFO model plus a FIFO free-address tracker model with bypass.
module tb_shared_buffer_vc_list_ctrl;
  localparam int unsigned D  = 32;
  localparam int unsigned NV = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned VW = 2;
  localparam int unsigned CW = AW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_buffer_vc_list_ctrl_if #(
    .memory_bank_depth(D), .num_vcs(NV), .flit_data_width(W)
  ) bus ();

  shared_buffer_vc_list_ctrl #(
    .memory_bank_depth(D), .num_vcs(NV), .flit_data_width(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each VC is a circular FIFO of (address, data); tracker is a FIFO of free addresses.
  logic [AW-1:0] m_addr [NV][D];
  logic [W-1:0]  m_data [NV][D];
  int            m_hd   [NV];
  int            m_cnt  [NV];
  int            free_q [$];
  logic [W-1:0]  exp_rd_data;
  logic          exp_rd_valid;
  logic          exp_err;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    logic [NV*CW-1:0] ec;
    logic [NV-1:0]    ee;
    for (int v = 0; v < NV; v++) begin
      ec[v*CW +: CW] = CW'(m_cnt[v]);
      ee[v]          = (m_cnt[v] == 0);
    end
    check("rd_data_valid", W'(bus.rd_data_valid), W'(exp_rd_valid));
    check("rd_data", bus.rd_data, exp_rd_data);
    check("vc_count", W'(bus.vc_count), W'(ec));
    check("vc_empty", W'(bus.vc_empty), W'(ee));
    check("err_flag", W'(bus.err_flag), W'(exp_err));
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int a = 0; a < D; a++) free_q.push_back(a);
    for (int v = 0; v < NV; v++) begin
      m_hd[v]  = 0;
      m_cnt[v] = 0;
    end
    exp_rd_data  = '0;
    exp_rd_valid = 1'b0;
    exp_err      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset                   = 1'b1;
    bus.wr_valid            = 1'b1;
    bus.wr_vc               = '0;
    bus.wr_data             = '1;
    bus.rd_valid            = 1'b1;
    bus.rd_vc               = '0;
    bus.tracker_empty       = 1'b0;
    bus.available_flit_addr = '0;
    #1;
    check("rst_allocate", W'(bus.allocate_addr), W'(0));
    check("rst_reclaim", W'(bus.reclaim_addr), W'(0));
    @(posedge clk);
    model_reset();
    #1;
    check_regs();
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
  endtask

  task automatic cycle(input logic wv, input int wvc, input logic [W-1:0] wd,
                       input logic rv, input int rvc);
    logic          rfire, wfire, tempty, wready;
    logic [AW-1:0] freed, a;
    @(negedge clk);
    rfire  = rv && (m_cnt[rvc] > 0);
    freed  = rfire ? m_addr[rvc][m_hd[rvc]] : '0;
    tempty = (free_q.size() == 0);
    wready = !tempty || rfire;
    wfire  = wv && wready;
    bus.wr_valid            = wv;
    bus.wr_vc               = VW'(wvc);
    bus.wr_data             = wd;
    bus.rd_valid            = rv;
    bus.rd_vc               = VW'(rvc);
    bus.tracker_empty       = tempty;
    bus.available_flit_addr = tempty ? freed : AW'(free_q[0]);
    #1;
    check("wr_ready", W'(bus.wr_ready), W'(wready));
    check("allocate_addr", W'(bus.allocate_addr), W'(wfire));
    check("reclaim_addr", W'(bus.reclaim_addr), W'(rfire));
    if (rfire) check("freed_flit_addr", W'(bus.freed_flit_addr), W'(freed));
    @(posedge clk);
    exp_rd_valid = rfire;
    if (rfire) begin
      exp_rd_data = m_data[rvc][m_hd[rvc]];
      m_hd[rvc]   = (m_hd[rvc] + 1) % D;
      m_cnt[rvc]--;
    end
    if (wfire) begin
      a = tempty ? freed : AW'(free_q.pop_front());
      m_addr[wvc][(m_hd[wvc] + m_cnt[wvc]) % D] = a;
      m_data[wvc][(m_hd[wvc] + m_cnt[wvc]) % D] = wd;
      m_cnt[wvc]++;
    end
    if (rfire && !(wfire && tempty)) free_q.push_back(int'(freed));
`ifdef SHARED_BUF_ERR_CHK_EN
    if ((rv && !rfire) || (wv && !wready)) exp_err = 1'b1;
`endif
    #1;
    check_regs();
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.wr_vc = '0; bus.rd_vc = '0;
    bus.wr_data = '0; bus.tracker_empty = 1'b0; bus.available_flit_addr = '0;

    // Three flits through VC1, then an idle cycle.
    do_reset();
    cycle(1, 1, 64'hD0, 0, 0);
    cycle(1, 1, 64'hD1, 0, 0);
    cycle(1, 1, 64'hD2, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 1);
    cycle(0, 0, '0, 0, 0);

    // Interleaved VC0/VC2, drain, then reuse freed addresses.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, rnd64(), 0, 0);
      cycle(1, 2, rnd64(), 0, 0);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, rnd64(), 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0);

    // Fill the bank on VC3, stall a write, then bypass write to VC0 under a VC3 read.
    do_reset();
    for (int i = 0; i < D; i++) cycle(1, 3, rnd64(), 0, 0);
    cycle(1, 0, rnd64(), 0, 0);
    cycle(1, 0, 64'hB1A5, 1, 3);
    cycle(0, 0, '0, 1, 0);

    // Single-flit VC2 handoff, then read the new flit, then read empty VC2/VC0.
    do_reset();
    cycle(1, 2, 64'hAAAA, 0, 0);
    cycle(1, 2, 64'hBBBB, 1, 2);
    cycle(0, 0, '0, 1, 2);
    cycle(0, 0, '0, 1, 2);
    cycle(0, 0, '0, 1, 0);

    // Randomized traffic, with a reset partway to start the tracker fresh.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)), rnd64(),
            1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)));
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, NV - 1)), rnd64(),
            1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NV - 1)));
    end

    // Reset with ten flits buffered; allocation restarts at address 0.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, i % NV, rnd64(), 0, 0);
    do_reset();
    cycle(1, 1, 64'hC0DE, 0, 0);
    cycle(0, 0, '0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
